// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART bootloader that assembles a framed byte stream into
// 32-bit words and writes them into the program ROM from word 0 upward.
// Frame layout: MAGIC, LEN_HI, LEN_LO, LEN x 4 data bytes (MSB first), checksum.
// The CPU is held in reset while a frame is in flight or after a failed frame.
module imem_uart_loader #(
   parameter int          ADDR_W         = 14,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_en,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR
   } state_t;

   state_t        state, nxt;
   logic [15:0]   len;
   logic [15:0]   len_v;
   logic [23:0]   word;      // first three bytes of the word being assembled
   logic [1:0]    byte_idx;
   logic [7:0]    checksum;
   logic [TW-1:0] timer;
   logic          active, tmo, abort, take, start;

   // Next-state decode; an abort (load_en low or inter-byte timeout) beats any byte
   always_comb begin
      active = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHECK);
      tmo    = active && (timer == TW'(TIMEOUT_CYCLES - 1));
      abort  = active && (!load_en || tmo);
      take   = rx_valid && load_en && !abort;
      start  = 1'b0;
      len_v  = {len[15:8], rx_data};
      nxt    = state;
      if (abort) begin
         nxt = ERROR;
      end else if (take) begin
         case (state)
            IDLE, DONE, ERROR: if (rx_data == MAGIC) begin
               nxt   = LEN_HI;
               start = 1'b1;
            end
            LEN_HI: nxt = LEN_LO;
            LEN_LO: begin
               if (len_v == 16'd0)                              nxt = CHECK;
               else if (32'(len_v) > (32'd1 << ADDR_W))         nxt = ERROR;
               else                                             nxt = DATA;
            end
            DATA: if (byte_idx == 2'd3 && (32'(words_loaded) + 32'd1 == 32'(len)))
               nxt = CHECK;
            CHECK: nxt = (rx_data == checksum) ? DONE : ERROR;
            default: nxt = IDLE;
         endcase
      end
   end

   // Frame FSM with datapath and registered status/write outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         len          <= '0;
         word         <= '0;
         byte_idx     <= '0;
         checksum     <= '0;
         timer        <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
         words_loaded <= '0;
      end else begin
         state      <= nxt;
         imem_we    <= 1'b0;
         cpu_hold   <= (nxt != IDLE) && (nxt != DONE);
         load_done  <= (nxt == DONE);
         load_error <= (nxt == ERROR);

         // Inter-byte timer: restarts on every byte or state change, runs only mid-frame
         if (take || nxt != state) timer <= '0;
         else if (active)          timer <= timer + 1'b1;

         if (start) begin
            words_loaded <= '0;
            checksum     <= '0;
            byte_idx     <= '0;
            word         <= '0;
         end else if (take) begin
            case (state)
               LEN_HI: len[15:8] <= rx_data;
               LEN_LO: len[7:0]  <= rx_data;
               DATA: begin
                  word     <= {word[15:0], rx_data};
                  checksum <= checksum + rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  // Fourth byte completes the word; write lands on the following cycle
                  if (byte_idx == 2'd3) begin
                     imem_we      <= 1'b1;
                     imem_wdata   <= {word, rx_data};
                     imem_addr    <= words_loaded[ADDR_W-1:0];
                     words_loaded <= words_loaded + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
